// File: rtl/pwm_duty_seq.sv
// Duty-cycle sequencer for the pwm block: off / steady / breathe / blink, paced by a prescaler tick.
// Define PWM_DUTY_SEQ_SYNC_IN_EN to pass enable/mode/level through 2-flop synchronizers.
module pwm_duty_seq #(
    parameter int DUTY_MAX   = 100,
    parameter int STEP_DIV   = 500000,
    parameter int HOLD_STEPS = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [6:0] level,
    output logic [6:0] duty_cycle,
    output logic       busy,
    output logic       period_done
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = $clog2(HOLD_STEPS + 1);
    localparam logic [PW-1:0] PLAST = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HLAST = HW'(HOLD_STEPS - 1);
    localparam logic [6:0]    DMAX  = 7'(DUTY_MAX);

    typedef enum logic [2:0] {
        S_OFF, S_STEADY, S_RAMP_UP, S_HOLD_HI, S_RAMP_DOWN, S_HOLD_LO
    } state_e;

    typedef enum logic [1:0] {
        C_OFF, C_STEADY, C_BREATHE, C_BLINK
    } cmd_e;

    logic       en_s;
    logic [1:0] mode_s;
    logic [6:0] level_s;

`ifdef PWM_DUTY_SEQ_SYNC_IN_EN
    logic [9:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {enable, mode, level};
            sync2_q <= sync1_q;
        end
    end

    assign {en_s, mode_s, level_s} = sync2_q;
`else
    assign en_s    = enable;
    assign mode_s  = mode;
    assign level_s = level;
`endif

    state_e        state_q, state_d;
    cmd_e          cmd, cmd_q;
    logic [6:0]    duty_q, duty_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          busy_q, busy_d;
    logic          pdone_q, pdone_d;
    logic          cmd_chg, tick, step, hold_done;
    logic [6:0]    lvl_c;

    assign cmd       = (!en_s || mode_s == 2'b00) ? C_OFF : cmd_e'(mode_s);
    assign cmd_chg   = (cmd != cmd_q);
    assign tick      = (pcnt_q == PLAST);
    // A command change discards a coincident tick.
    assign step      = tick && !cmd_chg;
    assign hold_done = step && (hcnt_q == HLAST);
    assign lvl_c     = (level_s > DMAX) ? DMAX : level_s;

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        pcnt_d  = pcnt_q;
        hcnt_d  = hcnt_q;
        pdone_d = 1'b0;

        if (cmd_chg || cmd == C_OFF) pcnt_d = '0;
        else                         pcnt_d = tick ? '0 : pcnt_q + PW'(1);

        if (cmd_chg)   hcnt_d = '0;
        else if (step) hcnt_d = hcnt_q + HW'(1);

        case (cmd)
            C_OFF: begin
                state_d = S_OFF;
                duty_d  = '0;
                hcnt_d  = '0;
            end
            C_STEADY: begin
                state_d = S_STEADY;
                duty_d  = lvl_c;
            end
            C_BREATHE: begin
                if (cmd_chg || !(state_q inside {S_RAMP_UP, S_HOLD_HI, S_RAMP_DOWN, S_HOLD_LO})) begin
                    state_d = S_RAMP_UP;
                    hcnt_d  = '0;
                end else begin
                    case (state_q)
                        S_RAMP_UP: begin
                            hcnt_d = '0;
                            if (step) begin
                                if (duty_q >= DMAX) begin
                                    duty_d  = DMAX;
                                    state_d = S_HOLD_HI;
                                end else begin
                                    duty_d = duty_q + 7'd1;
                                    if (duty_q == DMAX - 7'd1) state_d = S_HOLD_HI;
                                end
                            end
                        end
                        S_HOLD_HI: begin
                            if (hold_done) begin
                                hcnt_d  = '0;
                                state_d = S_RAMP_DOWN;
                            end
                        end
                        S_RAMP_DOWN: begin
                            hcnt_d = '0;
                            if (step) begin
                                if (duty_q <= 7'd1) begin
                                    duty_d  = '0;
                                    state_d = S_HOLD_LO;
                                end else begin
                                    duty_d = duty_q - 7'd1;
                                end
                            end
                        end
                        S_HOLD_LO: begin
                            if (hold_done) begin
                                hcnt_d  = '0;
                                state_d = S_RAMP_UP;
                                pdone_d = 1'b1;
                            end
                        end
                        default: state_d = S_RAMP_UP;
                    endcase
                end
            end
            C_BLINK: begin
                if (cmd_chg || !(state_q inside {S_HOLD_HI, S_HOLD_LO})) begin
                    state_d = S_HOLD_HI;
                    duty_d  = lvl_c;
                    hcnt_d  = '0;
                end else if (state_q == S_HOLD_HI) begin
                    // level is tracked live while high
                    duty_d = lvl_c;
                    if (hold_done) begin
                        hcnt_d  = '0;
                        duty_d  = '0;
                        state_d = S_HOLD_LO;
                    end
                end else begin
                    duty_d = '0;
                    if (hold_done) begin
                        hcnt_d  = '0;
                        duty_d  = lvl_c;
                        state_d = S_HOLD_HI;
                        pdone_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_OFF;
                duty_d  = '0;
            end
        endcase

        busy_d = (state_d != S_OFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_OFF;
            cmd_q   <= C_OFF;
            duty_q  <= '0;
            pcnt_q  <= '0;
            hcnt_q  <= '0;
            busy_q  <= 1'b0;
            pdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd;
            duty_q  <= duty_d;
            pcnt_q  <= pcnt_d;
            hcnt_q  <= hcnt_d;
            busy_q  <= busy_d;
            pdone_q <= pdone_d;
        end
    end

    assign duty_cycle  = duty_q;
    assign busy        = busy_q;
    assign period_done = pdone_q;

endmodule

// File: tb/tb_pwm_duty_seq.sv
// Directed bench for pwm_duty_seq at DUTY_MAX=10, STEP_DIV=4, HOLD_STEPS=2.
// XL is the extra input latency added when PWM_DUTY_SEQ_SYNC_IN_EN is defined.
module tb_pwm_duty_seq;

    localparam int DUTY_MAX   = 10;
    localparam int STEP_DIV   = 4;
    localparam int HOLD_STEPS = 2;
`ifdef PWM_DUTY_SEQ_SYNC_IN_EN
    localparam int XL = 2;
`else
    localparam int XL = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] mode;
    logic [6:0] level;
    logic [6:0] duty_cycle;
    logic       busy;
    logic       period_done;

    int nvec  = 0;
    int nfail = 0;

    pwm_duty_seq #(
        .DUTY_MAX  (DUTY_MAX),
        .STEP_DIV  (STEP_DIV),
        .HOLD_STEPS(HOLD_STEPS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .level      (level),
        .duty_cycle (duty_cycle),
        .busy       (busy),
        .period_done(period_done)
    );

    always #5 clk = ~clk;

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int ed;
        rst_n  = 1'b0;
        enable = 1'b1;
        mode   = 2'b10;
        level  = 7'd0;

        // reset held with breathe requested
        adv(3);
        chk("rst_duty", duty_cycle, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pdone", period_done, 0);

        // full breathe cycle from 0; c counts clocks since RAMP_UP entry
        rst_n = 1'b1;
        adv(1 + XL);
        chk("entry_busy", busy, 1);
        chk("entry_duty", duty_cycle, 0);
        for (int c = 1; c <= 97; c++) begin
            adv(1);
            if (c < 40)      ed = c / 4;
            else if (c < 52) ed = 10;
            else if (c < 88) ed = 10 - (c - 48) / 4;
            else             ed = 0;
            chk($sformatf("br_duty@%0d", c), duty_cycle, ed);
            chk($sformatf("br_pdone@%0d", c), period_done, (c == 96) ? 1 : 0);
        end
        adv(3);
        chk("br2_duty1", duty_cycle, 1);
        adv(20);
        chk("br2_duty6", duty_cycle, 6);

        // breathe -> steady at duty 6, then back to breathe
        mode  = 2'b01;
        level = 7'd8;
        adv(1 + XL);
        chk("mid_steady", duty_cycle, 8);
        mode = 2'b10;
        adv(1 + XL);
        chk("mid_resume", duty_cycle, 8);
        adv(3);
        chk("mid_pcnt_clr", duty_cycle, 8);
        adv(1);
        chk("mid_step", duty_cycle, 9);
        adv(4);
        chk("mid_top", duty_cycle, 10);
        adv(2);
        enable = 1'b0;
        adv(1 + XL);
        chk("dis_duty", duty_cycle, 0);
        chk("dis_busy", busy, 0);

        // steady clamp
        enable = 1'b1;
        mode   = 2'b01;
        level  = 7'd50;
        adv(1 + XL);
        chk("st_clamp", duty_cycle, 10);
        chk("st_busy", busy, 1);
        level = 7'd3;
        adv(1 + XL);
        chk("st_lvl3", duty_cycle, 3);
        level = 7'd50;
        adv(1 + XL);
        chk("st_lvl50", duty_cycle, 10);

        // breathe entered at DUTY_MAX: HOLD_HI on first tick; level ignored
        mode = 2'b10;
        adv(1 + XL);
        chk("bmax_entry", duty_cycle, 10);
        adv(4);
        chk("bmax_t4", duty_cycle, 10);
        adv(8);
        chk("bmax_t12", duty_cycle, 10);
        adv(4);
        chk("bmax_t16", duty_cycle, 9);
        level = 7'd0;
        adv(4);
        chk("bmax_t20", duty_cycle, 8);

        // blink 7/0 every 8 clocks
        mode  = 2'b11;
        level = 7'd7;
        adv(1 + XL);
        chk("bl_entry", duty_cycle, 7);
        for (int c = 1; c <= 33; c++) begin
            adv(1);
            chk($sformatf("bl_duty@%0d", c), duty_cycle, ((c / 8) % 2 == 0) ? 7 : 0);
            chk($sformatf("bl_pdone@%0d", c), period_done, (c == 16 || c == 32) ? 1 : 0);
        end
        level = 7'd4;
        adv(1 + XL);
        chk("bl_lvl_live", duty_cycle, 4);

        // reset mid-ramp
        mode  = 2'b01;
        level = 7'd2;
        adv(1 + XL);
        chk("rr_steady", duty_cycle, 2);
        mode = 2'b10;
        adv(1 + XL);
        chk("rr_entry", duty_cycle, 2);
        adv(4);
        chk("rr_step", duty_cycle, 3);
        adv(2);
        rst_n = 1'b0;
        #1;
        chk("rr_duty", duty_cycle, 0);
        chk("rr_busy", busy, 0);
        chk("rr_pdone", period_done, 0);
        adv(2);
        chk("rr_hold", duty_cycle, 0);

        // input-to-output latency
        rst_n  = 1'b1;
        enable = 1'b1;
        mode   = 2'b00;
        level  = 7'd0;
        adv(4);
        chk("lat_idle_busy", busy, 0);
        mode  = 2'b01;
        level = 7'd5;
`ifdef PWM_DUTY_SEQ_SYNC_IN_EN
        adv(2);
        chk("lat_early", duty_cycle, 0);
`endif
        adv(1);
        chk("lat_duty", duty_cycle, 5);
        chk("lat_busy", busy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
